// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream, holds the CPU in reset until the image is in.
// Latency: load_start -> HDR_LO next cycle; 2 header bytes; then 4 byte accepts + 1 write cycle per word (1 + 2 + 5N to DONE).
// Backpressure: byte_ready is decoded from state only (high in HDR_LO/HDR_HI/DATA); bytes offered at other times are not consumed.
//
// Ports:
//   clk         rising-edge system clock
//   reset       asynchronous active-low reset
//   load_start  one-cycle request to begin a load (honoured in IDLE, DONE, ERROR)
//   byte_valid  byte_data carries a stream byte
//   byte_data   stream byte: 16-bit word count N (LSB first), then N little-endian 32-bit words
//   byte_ready  loader accepts a byte on this cycle's rising edge if byte_valid is high
//   imem_we     one-cycle instruction memory write strobe
//   imem_addr   word address, held between writes
//   imem_wdata  instruction word, held between writes
//   cpu_hold    active-high reset to the CPU core, low only once the image is complete
//   load_done   image loaded, core released
//   load_error  header word count was 0 or larger than DEPTH, core kept in reset
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;               // word count from the header
  logic [ADDR_W:0]   word_idx_q, word_idx_d; // one spare bit so a count of DEPTH never wraps
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;           // first three bytes of the word in flight
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic [15:0] n_hdr;
  logic        hdr_bad;
  logic        last_word;

  // byte_ready depends only on the state register, so there is no path
  // from byte_valid back to byte_ready.
  assign byte_ready = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) || (state_q == S_DATA);
  assign accept     = byte_valid && byte_ready;

  // Full count as it will be once the high header byte lands this cycle.
  assign n_hdr   = {byte_data, n_q[7:0]};
  assign hdr_bad = (n_hdr == 16'd0) || ({1'b0, n_hdr} > 17'(DEPTH));

  // Compared at 32 bits so the zero-extension of word_idx is explicit;
  // n_q is never 0 here because a zero header goes to ERROR.
  assign last_word = (32'(word_idx_q) == (32'(n_q) - 32'd1));

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_HDR_LO;
        end
      end

      S_HDR_LO: begin
        if (accept) begin
          n_d[7:0] = byte_data;
          state_d  = S_HDR_HI;
        end
      end

      S_HDR_HI: begin
        if (accept) begin
          n_d = n_hdr;
          if (hdr_bad) begin
            state_d = S_ERROR;
          end else begin
            word_idx_d = '0;
            byte_idx_d = 2'd0;
            state_d    = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Address and data are captured here so they are already
            // stable for the whole WRITE cycle and then simply hold.
            addr_d  = word_idx_q[ADDR_W-1:0];
            wdata_d = {byte_data, asm_q};
            state_d = S_WRITE;
          end else begin
            // Bytes arrive LSB first, so shifting in from the top leaves
            // byte 0 in asm_q[7:0] after three bytes.
            asm_d = {byte_data, asm_q[23:8]};
          end
        end
      end

      S_WRITE: begin
        byte_idx_d = 2'd0;
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          word_idx_d = word_idx_q + (ADDR_W+1)'(1);
          state_d    = S_DATA;
        end
      end

      S_DONE: begin
        if (load_start) begin
          state_d = S_HDR_LO;
        end
      end

      S_ERROR: begin
        if (load_start) begin
          state_d = S_HDR_LO;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= 16'd0;
      word_idx_q <= '0;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Status outputs are pure decodes of the state register; reset forces
  // IDLE, which gives cpu_hold=1 and everything else 0 without a clock.
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign load_done  = (state_q == S_DONE);
  assign load_error = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus for imem_loader with a write scoreboard.
// Latency: checks the 1 + 2 + 5N start-to-done count with byte_valid held high.
// Backpressure: bytes are re-offered until byte_ready is seen; gapped mode toggles byte_valid.
module tb_imem_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              reset;
  logic              load_start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;
  int cyc   = 0;

  logic [63:0] sb_q[$];          // {addr, data} of each expected write
  logic [31:0] img[0:DEPTH-1];
  int          img_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [63:0] e;
      n_wr++;
      chk("we_while_ready", 64'(byte_ready), 64'd0);
      chk("we_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("we_addr", 64'(imem_addr), 64'(e[41:32]));
        chk("we_data", 64'(imem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic set_img1();
    img_n  = 3;
    img[0] = 32'h00500093;
    img[1] = 32'h00A00113;
    img[2] = 32'h002081B3;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int  guard;
    bit  sent;
    guard = 0;
    sent  = 1'b0;
    while (!sent) begin
      if (gap) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      sent = (byte_ready === 1'b1);
      @(negedge clk);
      guard++;
      if (!sent && guard > 20) begin
        n_bad++;
        $display("FAIL byte_accept_timeout: byte_ready stuck at %b, required 1", byte_ready);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "byte stream stalled");
      end
    end
  endtask

  task automatic send_b(input logic [7:0] b, input bit gap, input bit pulse);
    if (pulse) load_start = 1'b1;
    send_byte(b, gap);
    load_start = 1'b0;
  endtask

  task automatic do_load(input bit gap, input int start_at);
    logic [15:0] n;
    int k;
    n = 16'(img_n);
    k = 0;
    send_b(n[7:0], gap, start_at == k);  k++;
    send_b(n[15:8], gap, start_at == k); k++;
    for (int w = 0; w < img_n; w++) begin
      sb_q.push_back({22'd0, 10'(w), img[w]});
      for (int b = 0; b < 4; b++) begin
        send_b(img[w][8*b +: 8], gap, start_at == k);
        k++;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(output int at);
    int g;
    g = 0;
    while (load_done !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    at = cyc;
    chk("done_seen", 64'(load_done), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    chk({tag, "_imem_we"},    64'(imem_we),    64'd0);
    chk({tag, "_imem_addr"},  64'(imem_addr),  64'd0);
    chk({tag, "_imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_cpu_hold"},   64'(cpu_hold),   64'd1);
    chk({tag, "_load_done"},  64'(load_done),  64'd0);
    chk({tag, "_load_error"}, 64'(load_error), 64'd0);
  endtask

  initial begin
    int start_c;
    int done_c;
    int wr_before;

    reset      = 1'b1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Asynchronous reset before the first clock edge.
    #2 reset = 1'b0;
    #1 chk_reset_vals("rst_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Normal load with byte_valid held high.
    set_img1();
    start_c = cyc;
    pulse_start();
    do_load(1'b0, -1);
    wait_done(done_c);
    chk("normal_latency", 64'(done_c - start_c), 64'd18);
    chk("normal_cpu_hold", 64'(cpu_hold), 64'd0);
    chk("normal_sb_empty", 64'(sb_q.size()), 64'd0);

    // Restart from DONE with a different two-word image.
    pulse_start();
    chk("restart_done_clr", 64'(load_done), 64'd0);
    chk("restart_hold", 64'(cpu_hold), 64'd1);
    chk("restart_ready", 64'(byte_ready), 64'd1);
    img_n  = 2;
    img[0] = 32'hDEADBEEF;
    img[1] = 32'h12345678;
    do_load(1'b0, -1);
    wait_done(done_c);
    chk("restart_sb_empty", 64'(sb_q.size()), 64'd0);

    // Gapped stream.
    set_img1();
    start_c = cyc;
    pulse_start();
    do_load(1'b1, -1);
    wait_done(done_c);
    chk("gap_later", 64'((done_c - start_c) > 18), 64'd1);
    chk("gap_sb_empty", 64'(sb_q.size()), 64'd0);

    // load_start held across a WRITE and the following DATA cycle is ignored.
    start_c = cyc;
    pulse_start();
    do_load(1'b0, 6);
    wait_done(done_c);
    chk("midstart_latency", 64'(done_c - start_c), 64'd18);
    chk("midstart_sb_empty", 64'(sb_q.size()), 64'd0);

    // Bad header: N = 0.
    wr_before = n_wr;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    byte_valid = 1'b0;
    chk("hdr0_error", 64'(load_error), 64'd1);
    chk("hdr0_hold", 64'(cpu_hold), 64'd1);
    chk("hdr0_done", 64'(load_done), 64'd0);
    chk("hdr0_ready", 64'(byte_ready), 64'd0);
    repeat (4) @(negedge clk);
    chk("hdr0_no_we", 64'(n_wr), 64'(wr_before));

    // Bad header: N = 1025.
    pulse_start();
    chk("err_clr", 64'(load_error), 64'd0);
    chk("err_ready", 64'(byte_ready), 64'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    byte_valid = 1'b0;
    chk("hdr1025_error", 64'(load_error), 64'd1);
    chk("hdr1025_hold", 64'(cpu_hold), 64'd1);
    repeat (4) @(negedge clk);
    chk("hdr1025_no_we", 64'(n_wr), 64'(wr_before));

    // Valid image after an error.
    set_img1();
    start_c = cyc;
    pulse_start();
    do_load(1'b0, -1);
    wait_done(done_c);
    chk("recover_latency", 64'(done_c - start_c), 64'd18);
    chk("recover_error", 64'(load_error), 64'd0);
    chk("recover_sb_empty", 64'(sb_q.size()), 64'd0);

    // Largest legal image: N = DEPTH, last write lands at DEPTH-1.
    img_n = DEPTH;
    for (int w = 0; w < DEPTH; w++) img[w] = $urandom;
    pulse_start();
    do_load(1'b0, -1);
    wait_done(done_c);
    chk("full_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("full_last_addr", 64'(imem_addr), 64'(DEPTH - 1));
    chk("full_error", 64'(load_error), 64'd0);

    // Reset after two bytes of word 1: only word 0 may be written.
    set_img1();
    pulse_start();
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    sb_q.push_back({22'd0, 10'd0, img[0]});
    for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 1'b0);
    send_byte(img[1][7:0], 1'b0);
    send_byte(img[1][15:8], 1'b0);
    #2 reset = 1'b0;
    #1 chk_reset_vals("rst_mid");
    byte_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_sb_empty", 64'(sb_q.size()), 64'd0);

    // Fresh load after reset starts again at address 0.
    start_c = cyc;
    pulse_start();
    do_load(1'b0, -1);
    wait_done(done_c);
    chk("post_rst_latency", 64'(done_c - start_c), 64'd18);
    chk("post_rst_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
